// File: rtl/char_pkg.sv
`default_nettype none
// ============================================================================
// char_pkg : shared widths, raster limits, FSM states and queue entry format
// Revision : 1.0
// ============================================================================
package char_pkg;

  localparam int CHAR_W   = 6;
  localparam int COL_W    = 6;
  localparam int ROW_W    = 3;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [CHAR_W-1:0] BLANK_CODE = 6'h3F;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [CHAR_W-1:0] code;
  } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/char_write_sched_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with full/empty flags and show-ahead read data
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  // Full blocks a push even when a pop happens the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/char_write_sched.sv
`default_nettype none
// ============================================================================
// char_write_sched : queues host character writes and issues them to the row
//                    buffers only during raster blanking; also bulk-clears.
// Revision         : 1.0
// ============================================================================
module char_write_sched
  import char_pkg::*;
#(
  parameter int                NUM_ROWS   = 4,
  parameter int                NUM_COLS   = 64,
  parameter int                FIFO_DEPTH = 8,
  parameter int                H_ACTIVE   = char_pkg::H_ACTIVE,
  parameter int                V_ACTIVE   = char_pkg::V_ACTIVE,
  parameter logic [CHAR_W-1:0] BLANK_CODE = char_pkg::BLANK_CODE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROW_W-1:0]    in_row,
  input  logic [COL_W-1:0]    in_col,
  input  logic [CHAR_W-1:0]   in_char,
  input  logic                clear_req,
  input  logic [9:0]          hcount,
  input  logic [8:0]          vcount,
  output logic [NUM_ROWS-1:0] wr_en,
  output logic [COL_W-1:0]    wr_col,
  output logic [CHAR_W-1:0]   wr_char,
  output logic                busy,
  output logic                range_err
);

  localparam logic [9:0]       H_LIM    = 10'(H_ACTIVE);
  localparam logic [8:0]       V_LIM    = 9'(V_ACTIVE);
  localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [COL_W:0]   COL_LIM  = (COL_W + 1)'(NUM_COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROW_W-1:0]  r_clr_row;
  logic [ROW_W-1:0]  w_clr_row_nxt;
  logic [COL_W-1:0]  r_clr_col;
  logic [COL_W-1:0]  w_clr_col_nxt;

  logic              w_blank;
  logic              w_accept;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  wr_req_t           w_push_req;
  wr_req_t           w_head;

  logic              w_issue;
  logic [ROW_W-1:0]  w_iss_row;
  logic [COL_W-1:0]  w_iss_col;
  logic [CHAR_W-1:0] w_iss_char;

  assign w_blank    = (hcount >= H_LIM) | (vcount >= V_LIM);
  assign in_ready   = ~w_full;
  assign w_accept   = in_valid & in_ready;
  assign w_in_range = ({1'b0, in_row} < ROW_LIM) & ({1'b0, in_col} < COL_LIM);
  assign w_push     = w_accept & w_in_range;
  assign w_push_req = '{row: in_row, col: in_col, code: in_char};
  assign busy       = (r_state == CLEAR) | ~w_empty;

  sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_req),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clr_row <= '0;
      r_clr_col <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_clr_col <= w_clr_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_row_nxt = r_clr_row;
    w_clr_col_nxt = r_clr_col;
    w_pop         = 1'b0;
    w_issue       = 1'b0;
    w_iss_row     = '0;
    w_iss_col     = '0;
    w_iss_char    = '0;
    case (r_state)
      IDLE: begin
        // A clear request takes priority over draining the queue.
        if (clear_req) begin
          w_state_nxt   = CLEAR;
          w_clr_row_nxt = '0;
          w_clr_col_nxt = '0;
        end else if (!w_empty && w_blank) begin
          w_pop      = 1'b1;
          w_issue    = 1'b1;
          w_iss_row  = w_head.row;
          w_iss_col  = w_head.col;
          w_iss_char = w_head.code;
        end
      end
      CLEAR: begin
        if (w_blank) begin
          w_issue    = 1'b1;
          w_iss_row  = r_clr_row;
          w_iss_col  = r_clr_col;
          w_iss_char = BLANK_CODE;
          if (r_clr_col == LAST_COL) begin
            w_clr_col_nxt = '0;
            if (r_clr_row == LAST_ROW) begin
              w_state_nxt = IDLE;
            end else begin
              w_clr_row_nxt = r_clr_row + ROW_W'(1);
            end
          end else begin
            w_clr_col_nxt = r_clr_col + COL_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobe, column and code are registered so the row buffers see one clean write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en     <= '0;
      wr_col    <= '0;
      wr_char   <= '0;
      range_err <= 1'b0;
    end else begin
      wr_en <= w_issue ? (NUM_ROWS'(1) << w_iss_row) : '0;
      if (w_issue) begin
        wr_col  <= w_iss_col;
        wr_char <= w_iss_char;
      end
      if (w_accept && !w_in_range) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
